// File: rtl/hex_print_sched.sv
// Purpose : round-robin scheduler that prints DATA_W-bit words as hex chars into the overlay text buffer.
// Latency : first char write one cycle after the requester handshake, then one char per accepted write.
// Backpr. : wr_ready low holds wr_en/wr_addr/wr_char stable; requesters see ready low while a word is emitted.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   a_valid/a_data/a_addr/a_ready requester A word, first-char address, handshake
//   b_valid/b_data/b_addr/b_ready requester B word, first-char address, handshake
//   wr_en/wr_addr/wr_char         registered char write to the text buffer (overlay encoding)
//   wr_ready                      text buffer accepts the current write
//   busy                          high while a word is being emitted

module nibble_to_char (
    input  logic [3:0] nib,
    output logic [6:0] chr
);
    // Overlay encoding is ASCII minus 32: '0'..'9' -> 16..25, 'a'..'f' -> 65..70.
    always_comb begin
        if (nib < 4'd10) chr = 7'd16 + {3'b000, nib};
        else             chr = 7'd55 + {3'b000, nib};
    end
endmodule

module hex_print_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_char,
    input  logic              wr_ready,
    output logic              busy
);
    localparam int NCH   = DATA_W / 4;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    logic              state;
    logic [DATA_W-1:0] shift;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  cnt;
    logic              rr_last;

    logic              a_fire;
    logic              b_fire;
    logic              take;
    logic              accept;
    logic [DATA_W-1:0] next_shift;
    logic [ADDR_W-1:0] addr_sel;
    logic [6:0]        nib_char;

    // Grants are combinational in IDLE only, and suppressed while reset is
    // asserted so no word can be captured in a reset cycle.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n && state == ST_IDLE) begin
            if (a_valid && (!b_valid || rr_last == REQ_B)) a_ready = 1'b1;
            else if (b_valid)                            b_ready = 1'b1;
        end
    end

    assign a_fire   = a_valid & a_ready;
    assign b_fire   = b_valid & b_ready;
    assign take     = a_fire | b_fire;
    assign accept   = (state == ST_EMIT) & wr_en & wr_ready;
    assign addr_sel = a_fire ? a_addr : b_addr;

    // The shift register value for the next cycle; its top nibble is what the
    // wr_char register will present, so one mapper serves both the first char
    // (straight from the requester word) and every following char.
    always_comb begin
        next_shift = shift << 4;
        if (take) next_shift = a_fire ? a_data : b_data;
    end

    nibble_to_char u_n2c (
        .nib (next_shift[DATA_W-1 -: 4]),
        .chr (nib_char)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            rr_last <= REQ_B;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_char <= 7'd16;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        shift   <= next_shift;
                        ptr     <= addr_sel;
                        cnt     <= CNT_W'(NCH - 1);
                        rr_last <= b_fire ? REQ_B : REQ_A;
                        state   <= ST_EMIT;
                        busy    <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_addr <= addr_sel;
                        wr_char <= nib_char;
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            // Last char done: returning to IDLE costs one
                            // cycle before the next grant can be taken.
                            wr_en <= 1'b0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            shift   <= next_shift;
                            ptr     <= ptr + 1'b1;
                            cnt     <= cnt - 1'b1;
                            wr_addr <= ptr + 1'b1;
                            wr_char <= nib_char;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hex_print_sched.sv
module tb_hex_print_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic [11:0] a_addr, b_addr;
    logic        a_ready, b_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_char;
    logic        wr_ready;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hex_print_sched #(.DATA_W(32), .ADDR_W(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_addr   (a_addr),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_addr   (b_addr),
        .b_ready  (b_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .wr_ready (wr_ready),
        .busy     (busy)
    );

    typedef struct {
        logic        use_b;
        logic [31:0] data;
        logic [11:0] addr;
        int          stall_idx;
        int          stall_len;
        logic [6:0]  ch [8];
        logic [11:0] ad [8];
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_char(input int i, input logic [11:0] ea, input logic [6:0] ec);
        chk($sformatf("wr_en[%0d]", i), {31'b0, wr_en}, 32'd1);
        chk($sformatf("wr_addr[%0d]", i), {20'b0, wr_addr}, {20'b0, ea});
        chk($sformatf("wr_char[%0d]", i), {25'b0, wr_char}, {25'b0, ec});
    endtask

    initial begin
        // Hand-computed vectors: 1234ABCD with a 3-cycle stall on the 2nd char,
        // 0F0F0F0F wrapping past the top of the address space (issued by B),
        // and the two words covering all 16 nibble values.
        tbl[0].use_b = 1'b0; tbl[0].data = 32'h1234ABCD; tbl[0].addr = 12'd100;
        tbl[0].stall_idx = 1; tbl[0].stall_len = 3;
        tbl[0].ch = '{7'd17, 7'd18, 7'd19, 7'd20, 7'd65, 7'd66, 7'd67, 7'd68};
        tbl[0].ad = '{12'd100, 12'd101, 12'd102, 12'd103, 12'd104, 12'd105, 12'd106, 12'd107};

        tbl[1].use_b = 1'b1; tbl[1].data = 32'h0F0F0F0F; tbl[1].addr = 12'd4094;
        tbl[1].stall_idx = -1; tbl[1].stall_len = 0;
        tbl[1].ch = '{7'd16, 7'd70, 7'd16, 7'd70, 7'd16, 7'd70, 7'd16, 7'd70};
        tbl[1].ad = '{12'd4094, 12'd4095, 12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5};

        tbl[2].use_b = 1'b0; tbl[2].data = 32'h01234567; tbl[2].addr = 12'd0;
        tbl[2].stall_idx = 0; tbl[2].stall_len = 1;
        tbl[2].ch = '{7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd22, 7'd23};
        tbl[2].ad = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7};

        tbl[3].use_b = 1'b0; tbl[3].data = 32'h89ABCDEF; tbl[3].addr = 12'd8;
        tbl[3].stall_idx = 7; tbl[3].stall_len = 2;
        tbl[3].ch = '{7'd24, 7'd25, 7'd65, 7'd66, 7'd67, 7'd68, 7'd69, 7'd70};
        tbl[3].ad = '{12'd8, 12'd9, 12'd10, 12'd11, 12'd12, 12'd13, 12'd14, 12'd15};

        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0; a_addr = '0; b_addr = '0; wr_ready = 1'b1;

        // Reset state, with a request pending to confirm ready stays low.
        a_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_wr_en",   {31'b0, wr_en}, 32'd0);
        chk("rst_busy",    {31'b0, busy}, 32'd0);
        chk("rst_wr_addr", {20'b0, wr_addr}, 32'd0);
        chk("rst_wr_char", {25'b0, wr_char}, 32'd16);
        chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
        a_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven words.
        for (int v = 0; v < 4; v++) begin
            if (tbl[v].use_b) begin
                b_valid = 1'b1; b_data = tbl[v].data; b_addr = tbl[v].addr;
            end else begin
                a_valid = 1'b1; a_data = tbl[v].data; a_addr = tbl[v].addr;
            end
            #1;
            chk($sformatf("v%0d_a_ready", v), {31'b0, a_ready}, {31'b0, ~tbl[v].use_b});
            chk($sformatf("v%0d_b_ready", v), {31'b0, b_ready}, {31'b0, tbl[v].use_b});
            chk($sformatf("v%0d_idle_wr_en", v), {31'b0, wr_en}, 32'd0);
            @(negedge clk);
            a_valid = 1'b0; b_valid = 1'b0;
            a_data = 32'hDEADBEEF; b_data = 32'hDEADBEEF;
            chk($sformatf("v%0d_busy", v), {31'b0, busy}, 32'd1);
            chk($sformatf("v%0d_emit_a_ready", v), {31'b0, a_ready}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                if (i == tbl[v].stall_idx) begin
                    wr_ready = 1'b0;
                    for (int s = 0; s < tbl[v].stall_len; s++) begin
                        chk_char(i, tbl[v].ad[i], tbl[v].ch[i]);
                        @(negedge clk);
                    end
                    wr_ready = 1'b1;
                end
                chk_char(i, tbl[v].ad[i], tbl[v].ch[i]);
                @(negedge clk);
            end
            chk($sformatf("v%0d_end_wr_en", v), {31'b0, wr_en}, 32'd0);
            chk($sformatf("v%0d_end_busy", v), {31'b0, busy}, 32'd0);
        end

        // Both requesters held valid: A, B, A, B with one idle cycle per word.
        do_reset();
        a_valid = 1'b1; a_data = 32'h0;        a_addr = 12'd200;
        b_valid = 1'b1; b_data = 32'hFFFFFFFF; b_addr = 12'd300;
        #1;
        for (int c = 0; c < 36; c++) begin
            chk($sformatf("rr_wr_en_c%0d", c), {31'b0, wr_en}, {31'b0, (c % 9) != 0});
            chk($sformatf("rr_a_ready_c%0d", c), {31'b0, a_ready},
                {31'b0, ((c % 9) == 0) && ((c / 9) % 2 == 0)});
            chk($sformatf("rr_b_ready_c%0d", c), {31'b0, b_ready},
                {31'b0, ((c % 9) == 0) && ((c / 9) % 2 == 1)});
            if ((c % 9) != 0)
                chk($sformatf("rr_char_c%0d", c), {25'b0, wr_char},
                    ((c / 9) % 2 == 0) ? 32'd16 : 32'd70);
            @(negedge clk);
            #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a word, then tie goes to A.
        a_valid = 1'b1; a_data = 32'h1234ABCD; a_addr = 12'd50;
        #1;
        chk("mid_a_ready", {31'b0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_char(i, 12'(50 + i), 7'(17 + i));
            @(negedge clk);
        end
        chk_char(3, 12'd53, 7'd20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_wr_en",   {31'b0, wr_en}, 32'd0);
        chk("mid_rst_busy",    {31'b0, busy}, 32'd0);
        chk("mid_rst_wr_char", {25'b0, wr_char}, 32'd16);
        chk("mid_rst_wr_addr", {20'b0, wr_addr}, 32'd0);
        @(negedge clk);
        chk("post_rst_no_write", {31'b0, wr_en}, 32'd0);
        a_valid = 1'b1; a_addr = 12'd60;
        b_valid = 1'b1; b_addr = 12'd70;
        #1;
        chk("tie_a_ready", {31'b0, a_ready}, 32'd1);
        chk("tie_b_ready", {31'b0, b_ready}, 32'd0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        chk_char(0, 12'd60, 7'd17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
